mac_rr_sched: RTL and testbench

Round-robin scheduler that shares one 4x4 multiply-accumulate datapath between two requesters. Each requester streams a job of operand pairs terminated by a `last` flag. The block grants the datapath to one requester per job, multiplies and accumulates each pair through a one-stage product pipeline, then returns the tagged dot-product on a valid/ready result port. It sits between the input-feature-map fetch logic and the result collector, in place of per-requester MAC instances.

---
 rtl/mac_pkg.sv | 16 +
 rtl/rr_arb2.sv | 25 ++
 rtl/mac_rr_sched.sv | 132 +++++++++++++
 tb/tb_mac_rr_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and defaults for the round-robin MAC scheduler
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int DW_DEF    = 4;
  localparam int ACC_W_DEF = 12;

  localparam logic [ACC_W_DEF-1:0] SAT_DEF = {ACC_W_DEF{1'b1}};

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_ptr,
  output logic [1:0] o_gnt,
  output logic       o_idx
);

  logic w_idx;

  // On contention the pointer decides; a lone request always wins.
  always_comb begin
    w_idx = 1'b0;
    if (i_req0 && i_req1) begin
      w_idx = i_ptr;
    end else if (i_req1) begin
      w_idx = 1'b1;
    end
  end

  assign o_idx = w_idx;
  assign o_gnt = (i_req0 || i_req1) ? (w_idx ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/mac_rr_sched.sv
// rtl/mac_rr_sched.sv - shares one saturating MAC between two job streams
module mac_rr_sched
  import mac_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DW-1:0]    req0_a,
  input  logic [DW-1:0]    req0_b,
  input  logic             req0_last,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DW-1:0]    req1_a,
  input  logic [DW-1:0]    req1_b,
  input  logic             req1_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_id,
  output logic             res_ovf
);

  localparam logic [ACC_W-1:0] W_SAT = {ACC_W{1'b1}};

  state_t              r_state;
  state_t              w_next;
  logic                r_gnt;
  logic [1:0]          r_gnt_oh;
  logic                r_ptr;
  logic                r_pv;
  logic                r_ovf;
  logic [2*DW-1:0]     r_pq;
  logic [ACC_W-1:0]    r_acc;

  logic [1:0]          w_arb_oh;
  logic                w_arb_idx;
  logic                w_any;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [DW-1:0]       w_sel_a;
  logic [DW-1:0]       w_sel_b;
  logic                w_accept;
  logic                w_res_hs;
  logic [2*DW-1:0]     w_prod;
  logic [ACC_W:0]      w_sum;

  rr_arb2 u_arb (
    .i_req0 (req0_valid),
    .i_req1 (req1_valid),
    .i_ptr  (r_ptr),
    .o_gnt  (w_arb_oh),
    .o_idx  (w_arb_idx)
  );

  assign w_any       = req0_valid | req1_valid;
  assign w_sel_valid = r_gnt ? req1_valid : req0_valid;
  assign w_sel_last  = r_gnt ? req1_last  : req0_last;
  assign w_sel_a     = r_gnt ? req1_a     : req0_a;
  assign w_sel_b     = r_gnt ? req1_b     : req0_b;
  assign w_accept    = (r_state == ST_BUSY) & w_sel_valid;
  assign w_res_hs    = (r_state == ST_OUT) & res_ready;

  assign w_prod = {{DW{1'b0}}, w_sel_a} * {{DW{1'b0}}, w_sel_b};
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - 2*DW){1'b0}}, r_pq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next = ST_BUSY;
      ST_BUSY:  if (w_accept && w_sel_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_OUT;
      ST_OUT:   if (res_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (r_state == ST_BUSY) & r_gnt_oh[0];
    req1_ready = (r_state == ST_BUSY) & r_gnt_oh[1];
    res_valid  = (r_state == ST_OUT);
    res_data   = (r_state == ST_OUT) ? r_acc : '0;
    res_id     = (r_state == ST_OUT) & r_gnt;
    res_ovf    = (r_state == ST_OUT) & r_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= 1'b0;
      r_gnt_oh <= 2'b00;
      r_ptr    <= 1'b0;
      r_pv     <= 1'b0;
      r_pq     <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_pv <= w_accept;
      if (w_accept) begin
        r_pq <= w_prod;
      end
      if (r_state == ST_IDLE && w_any) begin
        r_gnt    <= w_arb_idx;
        r_gnt_oh <= w_arb_oh;
        r_acc    <= '0;
        r_ovf    <= 1'b0;
      end else if (r_pv) begin
        // Clamp instead of wrapping; ovf stays set until the next job starts.
        if (w_sum > {1'b0, W_SAT}) begin
          r_acc <= W_SAT;
          r_ovf <= 1'b1;
        end else begin
          r_acc <= w_sum[ACC_W-1:0];
        end
      end
      if (w_res_hs) begin
        r_ptr <= ~r_gnt;
      end
    end
  end

endmodule

// File: tb/tb_mac_rr_sched.sv
// tb/tb_mac_rr_sched.sv - directed self-checking bench for mac_rr_sched
module tb_mac_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_last, req1_last, res_ready;
  logic [3:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, res_valid, res_id, res_ovf;
  logic [11:0] res_data;
  logic        s_req0_ready, s_req1_ready, s_res_valid, s_res_id, s_res_ovf;
  logic [7:0]  s_res_data;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mac_rr_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_last(req1_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf)
  );

  // Narrow accumulator copy driven by the same stimulus, to reach saturation.
  mac_rr_sched #(.DW(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_last(req1_last),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data), .res_id(s_res_id), .res_ovf(s_res_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0; res_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    do_reset();

    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_readys", {req0_ready, req1_ready}, 0);

    // Single job on requester 0: 15 + 14 + 225 = 254
    req0_valid = 1; req0_a = 3; req0_b = 5; req0_last = 0;
    step();
    chk("j1_r0_ready", req0_ready, 1);
    chk("j1_r1_ready", req1_ready, 0);
    step();
    req0_a = 2; req0_b = 7;
    step();
    req0_a = 15; req0_b = 15; req0_last = 1;
    step();
    req0_valid = 0; req0_last = 0;
    chk("j1_drain_valid", res_valid, 0);
    chk("j1_drain_ready", req0_ready, 0);
    step();
    chk("j1_res_valid", res_valid, 1);
    chk("j1_res_data", res_data, 254);
    chk("j1_res_id", res_id, 0);
    chk("j1_res_ovf", res_ovf, 0);
    res_ready = 1;
    step();
    chk("j1_idle", res_valid, 0);
    res_ready = 0;

    // Contention after reset: requester 0 wins, requester 1 stalls
    do_reset();
    req0_valid = 1; req0_a = 4; req0_b = 4; req0_last = 1;
    req1_valid = 1; req1_a = 6; req1_b = 6; req1_last = 1;
    step();
    chk("c_r0_ready", req0_ready, 1);
    chk("c_r1_ready_busy", req1_ready, 0);
    step();
    req0_valid = 0; req0_last = 0;
    chk("c_r1_ready_drain", req1_ready, 0);
    res_ready = 1;
    step();
    chk("c_res0_valid", res_valid, 1);
    chk("c_res0_data", res_data, 16);
    chk("c_res0_id", res_id, 0);
    chk("c_r1_ready_out", req1_ready, 0);
    step();
    chk("c_idle_valid", res_valid, 0);
    step();
    chk("c_r1_ready", req1_ready, 1);
    chk("c_r0_ready_off", req0_ready, 0);
    step();
    req1_valid = 0; req1_last = 0;
    step();
    chk("c_res1_valid", res_valid, 1);
    chk("c_res1_data", res_data, 36);
    chk("c_res1_id", res_id, 1);
    step();
    res_ready = 0;

    // Rotation: pointer favours 0 after 1 was served
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_last = 1;
    req1_valid = 1; req1_a = 3; req1_b = 3; req1_last = 1;
    step();
    chk("rot_r0_ready", req0_ready, 1);
    chk("rot_r1_ready", req1_ready, 0);
    step();
    req0_valid = 0; req0_last = 0;
    step();
    chk("rot_res_data", res_data, 2);
    chk("rot_res_id", res_id, 0);
    res_ready = 1;
    step();
    res_ready = 0;
    step();
    chk("single_r1_ready", req1_ready, 1);
    step();
    req1_valid = 0; req1_last = 0;
    step();
    chk("single_res_data", res_data, 9);
    chk("single_res_id", res_id, 1);
    res_ready = 1;
    step();
    res_ready = 0;

    // Backpressure in OUT: outputs hold, no ready while requester 0 waits
    req1_valid = 1; req1_a = 2; req1_b = 3; req1_last = 1;
    step();
    step();
    req1_valid = 0; req1_last = 0;
    step();
    req0_valid = 1; req0_a = 5; req0_b = 5; req0_last = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 6);
      chk("bp_id", res_id, 1);
      chk("bp_readys", {req0_ready, req1_ready}, 0);
      step();
    end
    res_ready = 1;
    step();
    chk("bp_idle_valid", res_valid, 0);
    chk("bp_idle_readys", {req0_ready, req1_ready}, 0);
    req0_valid = 0; req0_last = 0;
    res_ready = 0;
    step();

    // Saturation with bubbles: 225 + 225 = 450 (12 bit), clamps to 255 (8 bit)
    req0_valid = 1; req0_a = 15; req0_b = 15; req0_last = 0;
    step();
    step();
    req0_valid = 0;
    step();
    chk("sat_bubble_ready", req0_ready, 1);
    step();
    req0_valid = 1; req0_last = 1;
    step();
    req0_valid = 0; req0_last = 0;
    step();
    chk("sat12_data", res_data, 450);
    chk("sat12_ovf", res_ovf, 0);
    chk("sat8_valid", s_res_valid, 1);
    chk("sat8_data", s_res_data, 255);
    chk("sat8_ovf", s_res_ovf, 1);
    res_ready = 1;
    step();
    res_ready = 0;

    // Reset mid-job after two of four beats
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_last = 0;
    step();
    step();
    req0_a = 3; req0_b = 4;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_readys", {req0_ready, req1_ready}, 0);
    chk("mid_rst_out", {res_valid, res_id, res_ovf}, 0);
    chk("mid_rst_data", res_data, 0);
    req0_valid = 0;
    step();
    rst_n = 1'b1;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_last = 1;
    step();
    chk("new_r0_ready", req0_ready, 1);
    step();
    req0_valid = 0; req0_last = 0;
    step();
    chk("new_res_valid", res_valid, 1);
    chk("new_res_data", res_data, 1);
    chk("new_res_ovf", res_ovf, 0);
    res_ready = 1;
    step();
    chk("new_idle", res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
